// File: rtl/sh7604_ibus_master.sv
// CPU-side initiator for the SH7604 on-chip peripheral bus (IBUS).
// Takes one CPU data access at a time and issues it on IBUS. It keeps REQ
// asserted while the peripheral reports BUSY, then returns steered read data
// to the core with a one-cycle ACK.
// Ports:
//   CLK, RST_N      clock, asynchronous active-low reset
//   CE_R, CE_F      rising/falling phase enables (CE_F is sampled only by peripherals)
//   EN, RES_N       block enable, synchronous soft reset (sampled on CE_R)
//   CPU_*           core-side request/response (A, DO, SZ, WE, REQ / DI, ACK, ERR)
//   IBUS_*          peripheral bus (A, DO, BA, WE, REQ / DI, BUSY, ACT)
module sh7604_ibus_master #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        CE_R,
    input  logic        CE_F,
    input  logic        EN,
    input  logic        RES_N,
    input  logic [31:0] CPU_A,
    input  logic [31:0] CPU_DO,
    input  logic [1:0]  CPU_SZ,
    input  logic        CPU_WE,
    input  logic        CPU_REQ,
    output logic [31:0] CPU_DI,
    output logic        CPU_ACK,
    output logic [1:0]  CPU_ERR,
    output logic [31:0] IBUS_A,
    output logic [31:0] IBUS_DO,
    input  logic [31:0] IBUS_DI,
    output logic [3:0]  IBUS_BA,
    output logic        IBUS_WE,
    output logic        IBUS_REQ,
    input  logic        IBUS_BUSY,
    input  logic        IBUS_ACT
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYC);

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_WORD = 2'd1;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_ALIGN   = 2'd1;
    localparam logic [1:0] ERR_NORESP  = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [1:0]       sz_q;
    logic             we_q;
    logic [CNT_W-1:0] cnt_q;

    logic             misalign_c;
    logic [3:0]       lanes_c;
    logic [31:0]      wdata_c;
    logic [31:0]      rdata_c;
    logic             ce_f_unused_c;

    // CE_F only matters to the peripherals, which sample REQ on it.
    assign ce_f_unused_c = CE_F;

    // Alignment check, byte lanes and lane-replicated write data for the incoming access.
    always_comb begin
        misalign_c = 1'b0;
        lanes_c    = 4'b1111;
        wdata_c    = CPU_DO;
        case (CPU_SZ)
            SZ_BYTE: begin
                lanes_c = 4'b1000 >> CPU_A[1:0];
                wdata_c = {4{CPU_DO[7:0]}};
            end
            SZ_WORD: begin
                misalign_c = CPU_A[0];
                lanes_c    = CPU_A[1] ? 4'b0011 : 4'b1100;
                wdata_c    = {2{CPU_DO[15:0]}};
            end
            default: begin
                misalign_c = (CPU_A[1:0] != 2'b00);
            end
        endcase
    end

    // Big-endian read steering into a right-justified, zero-extended result.
    always_comb begin
        rdata_c = IBUS_DI;
        case (sz_q)
            SZ_BYTE: begin
                case (IBUS_A[1:0])
                    2'd0:    rdata_c = {24'd0, IBUS_DI[31:24]};
                    2'd1:    rdata_c = {24'd0, IBUS_DI[23:16]};
                    2'd2:    rdata_c = {24'd0, IBUS_DI[15:8]};
                    default: rdata_c = {24'd0, IBUS_DI[7:0]};
                endcase
            end
            SZ_WORD: rdata_c = IBUS_A[1] ? {16'd0, IBUS_DI[15:0]} : {16'd0, IBUS_DI[31:16]};
            default: rdata_c = IBUS_DI;
        endcase
    end

    // Access sequencer: IDLE -> ISSUE -> WAIT -> DONE -> IDLE, advancing only on EN && CE_R.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= ST_IDLE;
            sz_q     <= 2'd0;
            we_q     <= 1'b0;
            cnt_q    <= '0;
            CPU_DI   <= '0;
            CPU_ACK  <= 1'b0;
            CPU_ERR  <= ERR_OK;
            IBUS_A   <= '0;
            IBUS_DO  <= '0;
            IBUS_BA  <= '0;
            IBUS_WE  <= 1'b0;
            IBUS_REQ <= 1'b0;
        end else if (CE_R && !RES_N) begin
            state    <= ST_IDLE;
            sz_q     <= 2'd0;
            we_q     <= 1'b0;
            cnt_q    <= '0;
            CPU_DI   <= '0;
            CPU_ACK  <= 1'b0;
            CPU_ERR  <= ERR_OK;
            IBUS_A   <= '0;
            IBUS_DO  <= '0;
            IBUS_BA  <= '0;
            IBUS_WE  <= 1'b0;
            IBUS_REQ <= 1'b0;
        end else if (EN && CE_R) begin
            case (state)
                ST_IDLE: begin
                    if (CPU_REQ) begin
                        sz_q  <= CPU_SZ;
                        we_q  <= CPU_WE;
                        cnt_q <= '0;
                        if (misalign_c) begin
                            // Rejected before any bus cycle is started.
                            CPU_DI  <= '0;
                            CPU_ERR <= ERR_ALIGN;
                            CPU_ACK <= 1'b1;
                            state   <= ST_DONE;
                        end else begin
                            IBUS_A   <= CPU_A;
                            IBUS_DO  <= wdata_c;
                            IBUS_BA  <= lanes_c;
                            IBUS_WE  <= CPU_WE;
                            IBUS_REQ <= 1'b1;
                            state    <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    // One full period so the peripheral sees REQ on the intervening CE_F.
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (IBUS_BUSY) begin
                        if ((cnt_q + CNT_W'(1)) == TIMEOUT_LIM) begin
                            IBUS_REQ <= 1'b0;
                            IBUS_WE  <= 1'b0;
                            CPU_DI   <= '0;
                            CPU_ERR  <= ERR_TIMEOUT;
                            CPU_ACK  <= 1'b1;
                            cnt_q    <= '0;
                            state    <= ST_DONE;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end else begin
                        IBUS_REQ <= 1'b0;
                        IBUS_WE  <= 1'b0;
                        CPU_ACK  <= 1'b1;
                        cnt_q    <= '0;
                        state    <= ST_DONE;
                        if (!IBUS_ACT) begin
                            CPU_DI  <= '0;
                            CPU_ERR <= ERR_NORESP;
                        end else begin
                            CPU_DI  <= we_q ? 32'd0 : rdata_c;
                            CPU_ERR <= ERR_OK;
                        end
                    end
                end
                ST_DONE: begin
                    // CPU_REQ still high here belongs to the access being acknowledged.
                    CPU_ACK <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
